// File: rtl/l2_tlb_mshr_coalesce.sv
// Coalescing MSHR for the L2 TLB. Each entry tracks one outstanding page-table walk,
// moving FREE -> WAITING -> ISSUED -> FREE. Misses on a VPN that is already pending
// are merged into that entry's destination mask, so one walk answers every requester.
//
// Handshake rule for the PTW request channel: a request transfers on a rising edge
// where ptw_req_valid_o && ptw_req_rdy_i. Once valid is raised, it and the VPN stay
// stable until the transfer happens; only clr_i withdraws it.
module l2_tlb_mshr_coalesce #(
  parameter int N_ENTRIES = 4,
  parameter int VPN_W     = 27,
  parameter int N_DEST    = 2,
  localparam int CW       = $clog2(N_ENTRIES + 1),
  localparam int IW       = $clog2(N_ENTRIES)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              add_valid_i,
  input  logic [VPN_W-1:0]  add_vpn_i,
  input  logic [N_DEST-1:0] add_dest_i,
  output logic              add_rdy_o,
  output logic              ptw_req_valid_o,
  output logic [VPN_W-1:0]  ptw_req_vpn_o,
  input  logic              ptw_req_rdy_i,
  input  logic              ptw_ans_valid_i,
  input  logic [VPN_W-1:0]  ptw_ans_vpn_i,
  output logic              ans_match_o,
  output logic [N_DEST-1:0] ans_dest_o,
  output logic              full_o,
  output logic [CW-1:0]     count_o
);

  typedef enum logic [1:0] {E_FREE = 2'd0, E_WAIT = 2'd1, E_ISSUED = 2'd2} ent_state_e;

  ent_state_e          r_state    [N_ENTRIES];
  logic [VPN_W-1:0]    r_vpn      [N_ENTRIES];
  logic [N_DEST-1:0]   r_dest     [N_ENTRIES];
  logic                r_lock;
  logic [IW-1:0]       r_lock_idx;

  ent_state_e          w_state_nxt[N_ENTRIES];
  logic [VPN_W-1:0]    w_vpn_nxt  [N_ENTRIES];
  logic [N_DEST-1:0]   w_dest_nxt [N_ENTRIES];
  logic                w_lock_nxt;
  logic [IW-1:0]       w_lock_idx_nxt;

  logic [N_ENTRIES-1:0] w_add_hit;
  logic [N_ENTRIES-1:0] w_ans_hit;
  logic                 w_any_wait;
  logic [IW-1:0]        w_wait_idx;
  logic                 w_free_any;
  logic [IW-1:0]        w_free_idx;
  logic [CW-1:0]        w_count;
  logic [N_DEST-1:0]    w_ans_dest;
  logic                 w_hit;
  logic                 w_full;
  logic                 w_alloc;
  logic                 w_req_valid;
  logic [IW-1:0]        w_sel_idx;
  logic                 w_fire;
  logic                 w_dup;

  // Lookup: lowest FREE / WAITING index, occupancy and add/answer VPN matches.
  // An entry retired by this cycle's answer is not a merge target.
  always_comb begin
    w_add_hit  = '0;
    w_ans_hit  = '0;
    w_any_wait = 1'b0;
    w_wait_idx = '0;
    w_free_any = 1'b0;
    w_free_idx = '0;
    w_count    = '0;
    w_ans_dest = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (r_state[i] == E_FREE) begin
        w_free_any = 1'b1;
        w_free_idx = IW'(i);
      end
      if (r_state[i] == E_WAIT) begin
        w_any_wait = 1'b1;
        w_wait_idx = IW'(i);
      end
    end
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (r_state[i] != E_FREE) w_count = w_count + {{(CW-1){1'b0}}, 1'b1};
      w_ans_hit[i] = ptw_ans_valid_i && (r_state[i] == E_ISSUED) && (r_vpn[i] == ptw_ans_vpn_i);
      w_add_hit[i] = add_valid_i && (r_state[i] != E_FREE) && !w_ans_hit[i] &&
                     (r_vpn[i] == add_vpn_i);
      if (w_ans_hit[i]) w_ans_dest = w_ans_dest | r_dest[i];
    end
  end

  assign w_hit           = |w_add_hit;
  assign w_full          = !w_free_any;
  assign full_o          = w_full;
  assign count_o         = w_count;
  assign add_rdy_o       = add_valid_i && !clr_i && (w_hit || !w_full);
  assign w_alloc         = add_rdy_o && !w_hit;
  assign w_req_valid     = r_lock || w_any_wait;
  assign w_sel_idx       = r_lock ? r_lock_idx : w_wait_idx;
  assign ptw_req_valid_o = w_req_valid && !clr_i;
  assign ptw_req_vpn_o   = ptw_req_valid_o ? r_vpn[w_sel_idx] : '0;
  assign w_fire          = ptw_req_valid_o && ptw_req_rdy_i;
  assign ans_match_o     = !clr_i && (|w_ans_hit);
  assign ans_dest_o      = clr_i ? '0 : w_ans_dest;

  // Next state of every entry and of the issue lock; clr_i wins over everything.
  always_comb begin
    w_state_nxt    = r_state;
    w_vpn_nxt      = r_vpn;
    w_dest_nxt     = r_dest;
    w_lock_nxt     = r_lock;
    w_lock_idx_nxt = r_lock_idx;
    if (clr_i) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        w_state_nxt[i] = E_FREE;
        w_dest_nxt[i]  = '0;
      end
      w_lock_nxt = 1'b0;
    end else begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        if (w_ans_hit[i]) begin
          w_state_nxt[i] = E_FREE;
          w_dest_nxt[i]  = '0;
        end else begin
          if (w_fire && (w_sel_idx == IW'(i))) w_state_nxt[i] = E_ISSUED;
          if (w_add_hit[i]) w_dest_nxt[i] = r_dest[i] | add_dest_i;
          if (w_alloc && (w_free_idx == IW'(i))) begin
            w_state_nxt[i] = E_WAIT;
            w_vpn_nxt[i]   = add_vpn_i;
            w_dest_nxt[i]  = add_dest_i;
          end
        end
      end
      if (w_req_valid && !ptw_req_rdy_i) begin
        w_lock_nxt     = 1'b1;
        w_lock_idx_nxt = w_sel_idx;
      end else if (w_fire) begin
        w_lock_nxt = 1'b0;
      end
    end
  end

  // Entry and lock registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        r_state[i] <= E_FREE;
        r_vpn[i]   <= '0;
        r_dest[i]  <= '0;
      end
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_vpn      <= w_vpn_nxt;
      r_dest     <= w_dest_nxt;
      r_lock     <= w_lock_nxt;
      r_lock_idx <= w_lock_idx_nxt;
    end
  end

  // Duplicate detector: two live entries holding the same VPN.
  always_comb begin
    w_dup = 1'b0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      for (int j = i + 1; j < N_ENTRIES; j++) begin
        if ((r_state[i] != E_FREE) && (r_state[j] != E_FREE) && (r_vpn[i] == r_vpn[j]))
          w_dup = 1'b1;
      end
    end
  end

  a_one_entry_per_vpn: assert property (@(posedge clk_i) disable iff (!rst_ni) !w_dup);

endmodule

// File: tb/tb_l2_tlb_mshr_coalesce.sv
// Directed bench for l2_tlb_mshr_coalesce: a table of per-cycle vectors plus a
// hand-written stall sequence whose issued VPNs are checked against an expected queue.
module tb_l2_tlb_mshr_coalesce;

  logic        clk_i;
  logic        rst_ni;
  logic        clr_i;
  logic        add_valid_i;
  logic [26:0] add_vpn_i;
  logic [1:0]  add_dest_i;
  logic        add_rdy_o;
  logic        ptw_req_valid_o;
  logic [26:0] ptw_req_vpn_o;
  logic        ptw_req_rdy_i;
  logic        ptw_ans_valid_i;
  logic [26:0] ptw_ans_vpn_i;
  logic        ans_match_o;
  logic [1:0]  ans_dest_o;
  logic        full_o;
  logic [2:0]  count_o;

  int checks = 0;
  int errors = 0;
  logic [26:0] exp_q[$];

  l2_tlb_mshr_coalesce #(.N_ENTRIES(4), .VPN_W(27), .N_DEST(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i),
    .add_valid_i(add_valid_i), .add_vpn_i(add_vpn_i), .add_dest_i(add_dest_i),
    .add_rdy_o(add_rdy_o),
    .ptw_req_valid_o(ptw_req_valid_o), .ptw_req_vpn_o(ptw_req_vpn_o),
    .ptw_req_rdy_i(ptw_req_rdy_i),
    .ptw_ans_valid_i(ptw_ans_valid_i), .ptw_ans_vpn_i(ptw_ans_vpn_i),
    .ans_match_o(ans_match_o), .ans_dest_o(ans_dest_o),
    .full_o(full_o), .count_o(count_o)
  );

  // Clock and reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        clr;
    logic        av;
    logic [26:0] avpn;
    logic [1:0]  ad;
    logic        rdy;
    logic        ansv;
    logic [26:0] ansvpn;
    logic        e_ardy;
    logic        e_rv;
    logic [26:0] e_rvpn;
    logic        e_am;
    logic [1:0]  e_ad;
    logic        e_full;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic clr, input logic av, input logic [26:0] avpn,
                              input logic [1:0] ad, input logic rdy, input logic ansv,
                              input logic [26:0] ansvpn, input logic e_ardy, input logic e_rv,
                              input logic [26:0] e_rvpn, input logic e_am, input logic [1:0] e_ad,
                              input logic e_full, input logic [2:0] e_cnt);
    vec_t v;
    v.clr = clr; v.av = av; v.avpn = avpn; v.ad = ad; v.rdy = rdy; v.ansv = ansv;
    v.ansvpn = ansvpn; v.e_ardy = e_ardy; v.e_rv = e_rv; v.e_rvpn = e_rvpn; v.e_am = e_am;
    v.e_ad = e_ad; v.e_full = e_full; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Driver: apply one cycle of inputs on the falling edge, settle, return before rising edge.
  task automatic drive(input logic clr, input logic av, input logic [26:0] avpn,
                       input logic [1:0] ad, input logic rdy, input logic ansv,
                       input logic [26:0] ansvpn);
    @(negedge clk_i);
    clr_i = clr; add_valid_i = av; add_vpn_i = avpn; add_dest_i = ad;
    ptw_req_rdy_i = rdy; ptw_ans_valid_i = ansv; ptw_ans_vpn_i = ansvpn;
    #1;
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, ".add_rdy"},   32'(add_rdy_o),       32'(v.e_ardy));
    chk({tag, ".req_valid"}, 32'(ptw_req_valid_o), 32'(v.e_rv));
    chk({tag, ".req_vpn"},   32'(ptw_req_vpn_o),   32'(v.e_rvpn));
    chk({tag, ".ans_match"}, 32'(ans_match_o),     32'(v.e_am));
    chk({tag, ".ans_dest"},  32'(ans_dest_o),      32'(v.e_ad));
    chk({tag, ".full"},      32'(full_o),          32'(v.e_full));
    chk({tag, ".count"},     32'(count_o),         32'(v.e_cnt));
  endtask

  // Scoreboard: an accepted request must carry the next VPN in the expected issue order.
  task automatic issue_chk(input string name);
    logic [26:0] e;
    chk({name, ".valid"}, 32'(ptw_req_valid_o), 32'd1);
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s unexpected issue vpn=%0h", name, ptw_req_vpn_o);
    end else begin
      e = exp_q.pop_front();
      chk({name, ".vpn"}, 32'(ptw_req_vpn_o), 32'(e));
    end
  endtask

  initial begin
    // Table: {clr, av, avpn, ad, rdy, ansv, ansvpn} -> {ardy, rv, rvpn, am, adst, full, cnt}
    vt.push_back(mk(0,0,27'h0,     2'b00,0,0,27'h0,      0,0,27'h0,  0,2'b00,0,3'd0)); // idle
    vt.push_back(mk(0,1,27'h123,   2'b01,0,0,27'h0,      1,0,27'h0,  0,2'b00,0,3'd0)); // alloc
    vt.push_back(mk(0,0,27'h0,     2'b00,0,0,27'h0,      0,1,27'h123,0,2'b00,0,3'd1)); // req, stall
    vt.push_back(mk(0,0,27'h0,     2'b00,1,0,27'h0,      0,1,27'h123,0,2'b00,0,3'd1)); // handshake
    vt.push_back(mk(0,1,27'h123,   2'b10,1,0,27'h0,      1,0,27'h0,  0,2'b00,0,3'd1)); // merge
    vt.push_back(mk(0,0,27'h0,     2'b00,1,1,27'h123,    0,0,27'h0,  1,2'b11,0,3'd1)); // answer
    vt.push_back(mk(0,0,27'h0,     2'b00,0,0,27'h0,      0,0,27'h0,  0,2'b00,0,3'd0)); // empty
    vt.push_back(mk(0,1,27'h1,     2'b01,0,0,27'h0,      1,0,27'h0,  0,2'b00,0,3'd0)); // A
    vt.push_back(mk(0,1,27'h2,     2'b01,0,0,27'h0,      1,1,27'h1,  0,2'b00,0,3'd1)); // B
    vt.push_back(mk(0,1,27'h3,     2'b10,0,0,27'h0,      1,1,27'h1,  0,2'b00,0,3'd2)); // C
    vt.push_back(mk(0,1,27'h4,     2'b10,0,0,27'h0,      1,1,27'h1,  0,2'b00,0,3'd3)); // D
    vt.push_back(mk(0,1,27'h5,     2'b01,0,0,27'h0,      0,1,27'h1,  0,2'b00,1,3'd4)); // full, new
    vt.push_back(mk(0,1,27'h2,     2'b10,0,0,27'h0,      1,1,27'h1,  0,2'b00,1,3'd4)); // full, merge
    vt.push_back(mk(0,0,27'h0,     2'b00,1,1,27'h7FFFF,  0,1,27'h1,  0,2'b00,1,3'd4)); // unknown ans
    vt.push_back(mk(0,0,27'h0,     2'b00,1,0,27'h0,      0,1,27'h2,  0,2'b00,1,3'd4)); // issue B
    vt.push_back(mk(0,0,27'h0,     2'b00,0,1,27'h2,      0,1,27'h3,  1,2'b11,1,3'd4)); // ans B
    vt.push_back(mk(0,1,27'h2,     2'b01,0,0,27'h0,      1,1,27'h3,  0,2'b00,0,3'd3)); // realloc B
    vt.push_back(mk(0,0,27'h0,     2'b00,0,1,27'h1,      0,1,27'h3,  1,2'b01,1,3'd4)); // ans A
    vt.push_back(mk(0,0,27'h0,     2'b00,1,0,27'h0,      0,1,27'h3,  0,2'b00,0,3'd3)); // issue C
    vt.push_back(mk(0,1,27'h3,     2'b01,0,1,27'h3,      1,1,27'h2,  1,2'b10,0,3'd3)); // ans C + add C
    vt.push_back(mk(0,0,27'h0,     2'b00,0,0,27'h0,      0,1,27'h2,  0,2'b00,0,3'd3)); // locked on B
    vt.push_back(mk(0,0,27'h0,     2'b00,1,0,27'h0,      0,1,27'h2,  0,2'b00,0,3'd3)); // issue B
    vt.push_back(mk(1,1,27'h9,     2'b01,1,1,27'h2,      0,0,27'h0,  0,2'b00,0,3'd3)); // clr wins
    vt.push_back(mk(0,0,27'h0,     2'b00,0,0,27'h0,      0,0,27'h0,  0,2'b00,0,3'd0)); // cleared

    rst_ni = 1'b0; clr_i = 1'b0; add_valid_i = 1'b0; add_vpn_i = '0; add_dest_i = '0;
    ptw_req_rdy_i = 1'b0; ptw_ans_valid_i = 1'b0; ptw_ans_vpn_i = '0;
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst.req_valid", 32'(ptw_req_valid_o), 32'd0);
    chk("rst.req_vpn",   32'(ptw_req_vpn_o),   32'd0);
    chk("rst.full",      32'(full_o),          32'd0);
    chk("rst.count",     32'(count_o),         32'd0);
    chk("rst.ans_match", 32'(ans_match_o),     32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int k = 0; k < vt.size(); k++) begin
      drive(vt[k].clr, vt[k].av, vt[k].avpn, vt[k].ad, vt[k].rdy, vt[k].ansv, vt[k].ansvpn);
      chk_all($sformatf("vec%0d", k), vt[k]);
    end

    // Stall: request locked on entry 1 while a lower-index entry becomes WAITING.
    exp_q.push_back(27'h100);
    exp_q.push_back(27'h200);
    exp_q.push_back(27'h050);
    drive(0, 1, 27'h100, 2'b01, 0, 0, 27'h0);
    drive(0, 1, 27'h200, 2'b10, 0, 0, 27'h0);
    chk("stall.lock_p", 32'(ptw_req_vpn_o), 32'h100);
    drive(0, 0, 27'h0,   2'b00, 1, 0, 27'h0);
    issue_chk("stall.issue_p");
    drive(0, 0, 27'h0,   2'b00, 0, 1, 27'h100);
    chk("stall.ans_p_match", 32'(ans_match_o), 32'd1);
    chk("stall.ans_p_dest",  32'(ans_dest_o),  32'h1);
    drive(0, 1, 27'h050, 2'b01, 0, 0, 27'h0);
    chk("stall.alloc_r_rdy", 32'(add_rdy_o), 32'd1);
    for (int c = 0; c < 5; c++) begin
      drive(0, 0, 27'h0, 2'b00, 0, 0, 27'h0);
      chk($sformatf("stall.hold%0d", c), 32'(ptw_req_vpn_o), 32'h200);
    end
    drive(0, 0, 27'h0, 2'b00, 1, 0, 27'h0);
    issue_chk("stall.issue_q");
    drive(0, 0, 27'h0, 2'b00, 1, 0, 27'h0);
    issue_chk("stall.issue_r");
    drive(0, 0, 27'h0, 2'b00, 0, 0, 27'h0);
    chk("stall.count2", 32'(count_o),         32'd2);
    chk("stall.idle",   32'(ptw_req_valid_o), 32'd0);
    drive(0, 0, 27'h0, 2'b00, 0, 1, 27'h200);
    chk("stall.ans_q_dest", 32'(ans_dest_o), 32'h2);
    drive(0, 0, 27'h0, 2'b00, 0, 1, 27'h050);
    chk("stall.ans_r_dest", 32'(ans_dest_o), 32'h1);
    drive(0, 0, 27'h0, 2'b00, 0, 0, 27'h0);
    chk("stall.count0", 32'(count_o), 32'd0);
    chk("stall.exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
